// File: rtl/video_timing_gen_pkg.sv
// rtl/video_timing_gen_pkg.sv - mode codes, per-mode timing tables and helpers
package video_timing_gen_pkg;

  typedef enum logic [1:0] {
    MODE_NTSC = 2'd0,
    MODE_PAL  = 2'd1,
    MODE_MONO = 2'd2
  } vmode_e;

  localparam logic [10:0] HSYNC_LEN = 11'd128;
  localparam logic [8:0]  VSYNC_LEN = 9'd3;

  typedef struct packed {
    logic [10:0] h_total;
    logic [10:0] h_act_start;
    logic [10:0] h_act_end;
    logic [8:0]  v_total;
    logic [8:0]  v_act_start;
    logic [8:0]  v_act_end;
  } timing_t;

  localparam timing_t TIMING_PAL = '{
    h_total: 11'd1728, h_act_start: 11'd264, h_act_end: 11'd1703,
    v_total: 9'd312,   v_act_start: 9'd22,   v_act_end: 9'd309
  };

  localparam timing_t TIMING_NTSC = '{
    h_total: 11'd1712, h_act_start: 11'd244, h_act_end: 11'd1683,
    v_total: 9'd263,   v_act_start: 9'd18,   v_act_end: 9'd257
  };

  function automatic timing_t timing_for(input logic pal);
    return pal ? TIMING_PAL : TIMING_NTSC;
  endfunction

  // Anything other than the NTSC code (including the mono code) runs PAL timing.
  function automatic logic mode_is_pal(input logic [1:0] mode);
    return mode != MODE_NTSC;
  endfunction

endpackage

// File: rtl/video_timing_gen_if.sv
// rtl/video_timing_gen_if.sv - timing output bundle from the generator to the HDMI encoder
interface video_timing_gen_if;
  logic        hs;
  logic        vs;
  logic        de;
  logic [10:0] hpos;
  logic [8:0]  vpos;
  logic        frame_start;
  logic        cur_mode;

  modport master (output hs, vs, de, hpos, vpos, frame_start, cur_mode);
  modport slave  (input  hs, vs, de, hpos, vpos, frame_start, cur_mode);
endinterface

// File: rtl/video_timing_axis.sv
// rtl/video_timing_axis.sv - one timing axis: wrapping counter with reload plus window compares
module video_timing_axis #(
  parameter int W = 11
) (
  input  logic         clk_i,
  input  logic         reset_i,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         en_i,
  input  logic [W-1:0] total_i,
  input  logic [W-1:0] sync_len_i,
  input  logic [W-1:0] act_start_i,
  input  logic [W-1:0] act_end_i,
  output logic [W-1:0] cnt_o,
  output logic         last_o,
  output logic         wrap_o,
  output logic         in_sync_o,
  output logic         in_act_o
);

  logic [W-1:0] cnt_q, cnt_d;
  logic [W-1:0] last_val;
  logic         at_end;

  // ">=" rather than "==" so a count left out of range by a table change still wraps.
  assign last_val = total_i - W'(1);
  assign at_end   = cnt_q >= last_val;

  // Reload beats counting; otherwise step and wrap at the end of the axis.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (en_i) begin
      cnt_d = at_end ? '0 : cnt_q + W'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o     = cnt_q;
  assign last_o    = cnt_q == last_val;
  assign wrap_o    = en_i && at_end;
  assign in_sync_o = cnt_q < sync_len_i;
  assign in_act_o  = (cnt_q >= act_start_i) && (cnt_q <= act_end_i);

endmodule

// File: rtl/video_timing_gen.sv
// rtl/video_timing_gen.sv - PAL/NTSC hs/vs/de generator with analyzer-driven resync
module video_timing_gen
  import video_timing_gen_pkg::*;
#(
  parameter logic [10:0] RESYNC_H = 11'd1,
  parameter logic [8:0]  RESYNC_V = 9'd18
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic [1:0]         mode_i,
  input  logic               vreset_i,
  video_timing_gen_if.master vid
);

  timing_t     tim;
  logic        cur_mode_q;
  logic [10:0] hcnt;
  logic [8:0]  vcnt;
  logic        h_last, h_wrap, h_sync, h_act;
  logic        v_last, v_wrap, v_sync, v_act;
  logic        frame_wrap;

  logic        hs_q, hs_d, vs_q, vs_d, de_q, de_d, fs_q, fs_d, cm_q, cm_d;
  logic [10:0] hpos_q, hpos_d;
  logic [8:0]  vpos_q, vpos_d;

  assign tim = timing_for(cur_mode_q);

  video_timing_axis #(.W(11)) u_h (
    .clk_i      (clk_i),
    .reset_i    (reset_i),
    .load_i     (vreset_i),
    .load_val_i (RESYNC_H),
    .en_i       (1'b1),
    .total_i    (tim.h_total),
    .sync_len_i (HSYNC_LEN),
    .act_start_i(tim.h_act_start),
    .act_end_i  (tim.h_act_end),
    .cnt_o      (hcnt),
    .last_o     (h_last),
    .wrap_o     (h_wrap),
    .in_sync_o  (h_sync),
    .in_act_o   (h_act)
  );

  video_timing_axis #(.W(9)) u_v (
    .clk_i      (clk_i),
    .reset_i    (reset_i),
    .load_i     (vreset_i),
    .load_val_i (RESYNC_V),
    .en_i       (h_wrap),
    .total_i    (tim.v_total),
    .sync_len_i (VSYNC_LEN),
    .act_start_i(tim.v_act_start),
    .act_end_i  (tim.v_act_end),
    .cnt_o      (vcnt),
    .last_o     (v_last),
    .wrap_o     (v_wrap),
    .in_sync_o  (v_sync),
    .in_act_o   (v_act)
  );

  // Only the exact last pixel of the frame counts; an out-of-range guard wrap does not latch a mode.
  assign frame_wrap = v_wrap && h_last && v_last;

  // Mode is only taken at a frame boundary or on resync, so timing never changes mid-frame.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      cur_mode_q <= 1'b1;
    end else if (vreset_i || frame_wrap) begin
      cur_mode_q <= mode_is_pal(mode_i);
    end
  end

  // Decode the current counters; positions hold outside the active area.
  always_comb begin
    hs_d   = !h_sync;
    vs_d   = !v_sync;
    de_d   = h_act && v_act;
    hpos_d = de_d ? hcnt - tim.h_act_start : hpos_q;
    vpos_d = de_d ? vcnt - tim.v_act_start : vpos_q;
    fs_d   = (hcnt == 11'd0) && (vcnt == 9'd0);
    cm_d   = cur_mode_q;
  end

  // Output registers: one cycle behind the counters, cur_mode kept aligned with the timing.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      hs_q   <= 1'b1;
      vs_q   <= 1'b1;
      de_q   <= 1'b0;
      hpos_q <= '0;
      vpos_q <= '0;
      fs_q   <= 1'b0;
      cm_q   <= 1'b1;
    end else begin
      hs_q   <= hs_d;
      vs_q   <= vs_d;
      de_q   <= de_d;
      hpos_q <= hpos_d;
      vpos_q <= vpos_d;
      fs_q   <= fs_d;
      cm_q   <= cm_d;
    end
  end

  assign vid.hs          = hs_q;
  assign vid.vs          = vs_q;
  assign vid.de          = de_q;
  assign vid.hpos        = hpos_q;
  assign vid.vpos        = vpos_q;
  assign vid.frame_start = fs_q;
  assign vid.cur_mode    = cm_q;

endmodule

// File: tb/tb_video_timing_gen.sv
// tb/tb_video_timing_gen.sv - frame-position model bench for video_timing_gen
module tb_video_timing_gen;

  // Resync line chosen close to the NTSC frame end so frame wraps are reachable quickly.
  localparam int RH = 1;
  localparam int RV = 256;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] mode = 2'd1;
  logic       vreset = 1'b0;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  video_timing_gen_if vid ();

  video_timing_gen #(.RESYNC_H(11'(RH)), .RESYNC_V(9'(RV))) dut (
    .clk_i   (clk),
    .reset_i (reset),
    .mode_i  (mode),
    .vreset_i(vreset),
    .vid     (vid)
  );

  always #5 clk = ~clk;

  // Timing tables as plain numbers.
  function automatic int htot(input bit pal); return pal ? 1728 : 1712; endfunction
  function automatic int vtot(input bit pal); return pal ? 312 : 263;   endfunction
  function automatic int hst (input bit pal); return pal ? 264 : 244;   endfunction
  function automatic int hen (input bit pal); return pal ? 1703 : 1683; endfunction
  function automatic int vst (input bit pal); return pal ? 22 : 18;     endfunction
  function automatic int ven (input bit pal); return pal ? 309 : 257;   endfunction

  // Model: a single linear position within the frame, decoded with div/mod.
  int pos;
  bit m_pal;
  bit mvalid = 1'b0;
  int mh, mv;
  bit e_hs = 1'b1, e_vs = 1'b1, e_de = 1'b0, e_fs = 1'b0, e_cm = 1'b1;
  int e_hpos = 0, e_vpos = 0;

  always @(posedge clk) begin
    cyc++;
    if (reset) begin
      pos = 0; m_pal = 1'b1; mvalid = 1'b1;
      e_hs = 1'b1; e_vs = 1'b1; e_de = 1'b0; e_fs = 1'b0; e_cm = 1'b1;
      e_hpos = 0; e_vpos = 0;
    end else begin
      mh = pos % htot(m_pal);
      mv = pos / htot(m_pal);
      e_hs = (mh >= 128);
      e_vs = (mv >= 3);
      e_de = (mh >= hst(m_pal)) && (mh <= hen(m_pal)) && (mv >= vst(m_pal)) && (mv <= ven(m_pal));
      if (e_de) begin
        e_hpos = mh - hst(m_pal);
        e_vpos = mv - vst(m_pal);
      end
      e_fs = (pos == 0);
      e_cm = m_pal;
      if (vreset) begin
        m_pal = (mode != 2'd0);
        pos = RV * htot(m_pal) + RH;
      end else if (pos == htot(m_pal) * vtot(m_pal) - 1) begin
        m_pal = (mode != 2'd0);
        pos = 0;
      end else begin
        pos++;
      end
    end
  end

  // Per-cycle compare of every output against the model.
  always @(negedge clk) begin
    if (mvalid) begin
      n_cmp++;
      if (vid.hs !== e_hs || vid.vs !== e_vs || vid.de !== e_de || vid.frame_start !== e_fs ||
          vid.cur_mode !== e_cm || vid.hpos !== 11'(e_hpos) || vid.vpos !== 9'(e_vpos)) begin
        n_bad++;
        $display("FAIL cycle t=%0t: dut hs=%b vs=%b de=%b fs=%b cm=%b hpos=%0d vpos=%0d, model hs=%b vs=%b de=%b fs=%b cm=%b hpos=%0d vpos=%0d",
                 $time, vid.hs, vid.vs, vid.de, vid.frame_start, vid.cur_mode, vid.hpos, vid.vpos,
                 e_hs, e_vs, e_de, e_fs, e_cm, e_hpos, e_vpos);
      end
    end
  end

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Waits for an hs falling edge, then measures low width and full period.
  task automatic measure_hs(input string tag, input int exp_low, input int exp_per);
    int n, low, per;
    n = 0;
    while (vid.hs !== 1'b1 && n < 4000) begin @(negedge clk); n++; end
    n = 0;
    while (vid.hs !== 1'b0 && n < 4000) begin @(negedge clk); n++; end
    low = 0;
    while (vid.hs === 1'b0 && low < 4000) begin @(negedge clk); low++; end
    per = low;
    while (vid.hs === 1'b1 && per < 4000) begin @(negedge clk); per++; end
    check({tag, "_hs_low"}, low, exp_low);
    check({tag, "_hs_period"}, per, exp_per);
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation time limit reached before completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, c0, f1, f2;
    bit prev_hs, prev_cm;

    // Reset values.
    repeat (3) @(negedge clk);
    check("rst_hs", vid.hs, 1);
    check("rst_vs", vid.vs, 1);
    check("rst_de", vid.de, 0);
    check("rst_hpos", vid.hpos, 0);
    check("rst_vpos", vid.vpos, 0);
    check("rst_fs", vid.frame_start, 0);
    check("rst_cm", vid.cur_mode, 1);

    // Free-running PAL from reset.
    reset = 1'b0;
    @(negedge clk);
    c0 = cyc;
    check("first_fs", vid.frame_start, 1);
    check("first_hs", vid.hs, 0);
    measure_hs("pal", 128, 1728);
    n = 0;
    while (vid.vs === 1'b0 && n < 20000) begin @(negedge clk); n++; end
    check("pal_vs_low_clocks", cyc - c0, 3 * 1728);

    // PAL resync: outputs reflect hcnt=RH, vcnt=RV two clocks after the pulse.
    repeat ($urandom_range(50, 900)) @(negedge clk);
    mode = 2'd1; vreset = 1'b1;
    @(negedge clk);
    vreset = 1'b0;
    @(negedge clk);
    check("resync_hs", vid.hs, 0);
    check("resync_vs", vid.vs, 1);
    check("resync_de", vid.de, 0);
    n = 0;
    while (vid.de !== 1'b1 && n < 3000) begin @(negedge clk); n++; end
    check("resync_de_delay", n, 264 - RH);
    check("resync_hpos", vid.hpos, 0);
    check("resync_vpos", vid.vpos, RV - 22);

    // Reset together with vreset mid-active-line: reset wins, counters restart from 0.
    reset = 1'b1; vreset = 1'b1; mode = 2'd0;
    @(negedge clk);
    check("rv_hs", vid.hs, 1);
    check("rv_vs", vid.vs, 1);
    check("rv_de", vid.de, 0);
    check("rv_fs", vid.frame_start, 0);
    check("rv_cm", vid.cur_mode, 1);
    reset = 1'b0; vreset = 1'b0;
    @(negedge clk);
    check("rv_restart_fs", vid.frame_start, 1);
    check("rv_restart_vs", vid.vs, 0);
    repeat (200) @(negedge clk);
    check("mode_mid_frame_ignored", vid.cur_mode, 1);

    // NTSC resync via a 3-cycle vreset burst, mode toggled mid-frame, PAL present at the wrap.
    mode = 2'd0; vreset = 1'b1;
    repeat (3) @(negedge clk);
    vreset = 1'b0;
    @(negedge clk);
    check("ntsc_cm", vid.cur_mode, 0);
    n = 0; f1 = 0; f2 = 0;
    prev_hs = vid.hs; prev_cm = vid.cur_mode;
    while (vid.frame_start !== 1'b1 && n < 20000) begin
      if (n == 2000) mode = 2'd1;
      if (n == 5000) mode = 2'd0;
      if (n == 8000) mode = 2'd3;
      prev_cm = vid.cur_mode;
      @(negedge clk);
      n++;
      if (prev_hs && vid.hs === 1'b0) begin
        if (f1 == 0) f1 = cyc;
        else if (f2 == 0) f2 = cyc;
      end
      prev_hs = vid.hs;
    end
    check("ntsc_fs_delay", n, (1712 - 1) + (263 - RV - 1) * 1712);
    check("ntsc_hs_period", f2 - f1, 1712);
    check("cm_before_wrap", prev_cm, 0);
    check("cm_after_wrap", vid.cur_mode, 1);
    measure_hs("pal_after_wrap", 128, 1728);

    // Randomized resyncs, mode changes and resets, covered by the per-cycle model compare.
    for (int it = 0; it < 8; it++) begin
      repeat ($urandom_range(1, 1500)) @(negedge clk);
      case ($urandom_range(0, 3))
        0: begin
          mode = 2'($urandom_range(0, 3)); vreset = 1'b1;
          @(negedge clk);
          vreset = 1'b0;
        end
        1: begin
          mode = 2'($urandom_range(0, 3)); vreset = 1'b1;
          repeat ($urandom_range(2, 4)) @(negedge clk);
          vreset = 1'b0;
        end
        2: mode = 2'($urandom_range(0, 3));
        default: begin
          reset = 1'b1; vreset = 1'($urandom_range(0, 1));
          repeat ($urandom_range(1, 3)) @(negedge clk);
          reset = 1'b0; vreset = 1'b0;
        end
      endcase
    end
    repeat (2000) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
